wb_cmd_master: RTL and testbench

- Synthesizable, parametrised Wishbone classic master engine; successor to the task-driven bus driver.
- Accepts read/write commands on a valid/ready channel and buffers them in a CMD_DEPTH FIFO.
- Issues one single-beat Wishbone cycle per command and returns data plus status (OK/ERR/TIMEOUT) on a valid/ready response channel.
- Sits between test/CPU-side control logic and any Wishbone slave (e.g. the I2C controller register file).

---
 rtl/wb_cmd_master.sv | 270 +++++++++++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// ----------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone classic master engine. Read/write commands arrive on a
//   valid/ready channel and wait in a CMD_DEPTH-entry FIFO. Each command
//   becomes one single-beat Wishbone cycle. The result (echoed we, read data
//   and OK/ERR/TIMEOUT status) is returned on a valid/ready response channel.
//
// Ports
//   clk_i, rst_i       clock (rising edge), async active-high reset
//   cmd_valid_i/ready_o command handshake; ready = FIFO not full
//   cmd_we_i/adr_i/dat_i command fields (dat ignored for reads)
//   rsp_valid_o/ready_i response handshake
//   rsp_we_o/dat_o/status_o response fields; status 00 OK, 01 ERR, 10 TIMEOUT
//   cmd_count_o        FIFO occupancy
//   busy_o             engine active or commands pending
//   cyc_o, stb_o, we_o, adr_o, dat_o   Wishbone master outputs
//   dat_i, ack_i, err_i                Wishbone slave inputs
// ----------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    // command channel
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic                           cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]          cmd_adr_i,
    input  logic [DATA_WIDTH-1:0]          cmd_dat_i,
    // response channel
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic                           rsp_we_o,
    output logic [DATA_WIDTH-1:0]          rsp_dat_o,
    output logic [1:0]                     rsp_status_o,
    // status
    output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count_o,
    output logic                           busy_o,
    // Wishbone master
    output logic                           cyc_o,
    output logic                           stb_o,
    output logic                           we_o,
    output logic [ADDR_WIDTH-1:0]          adr_o,
    output logic [DATA_WIDTH-1:0]          dat_o,
    input  logic [DATA_WIDTH-1:0]          dat_i,
    input  logic                           ack_i,
    input  logic                           err_i
);

    localparam int unsigned PTR_W   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(CMD_DEPTH + 1);
    localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RSP
    } state_t;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ENTRY_W-1:0]     r_mem [CMD_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_rst_done;

    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_adr;
    logic [DATA_WIDTH-1:0]  r_dat;
    logic [TO_W-1:0]        r_to_cnt;

    logic                   r_rsp_we;
    logic [DATA_WIDTH-1:0]  r_rsp_dat;
    logic [1:0]             r_rsp_status;

    logic                   w_push;
    logic                   w_launch;
    logic                   w_term;
    logic                   w_rsp_done;
    logic                   w_fifo_nempty;
    logic                   w_timeout;
    logic [ENTRY_W-1:0]     w_head;
    logic                   w_head_we;
    logic [ADDR_WIDTH-1:0]  w_head_adr;
    logic [DATA_WIDTH-1:0]  w_head_dat;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    // Ready comes from registered count only, so a full FIFO refuses a push
    // even in a cycle where the engine pops. r_rst_done keeps ready low
    // until the first edge after reset release.
    assign cmd_ready_o   = r_rst_done && (r_count != FULL_CNT);
    assign w_push        = cmd_valid_i && cmd_ready_o;
    assign w_fifo_nempty = (r_count != '0);

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_we  = w_head[ENTRY_W-1];
    assign w_head_adr = w_head[DATA_WIDTH +: ADDR_WIDTH];
    assign w_head_dat = w_head[DATA_WIDTH-1:0];

    // Storage carries no reset; occupancy is tracked by pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_we_i, cmd_adr_i, cmd_dat_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_launch) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_launch})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign w_timeout = TO_EN && (r_to_cnt == TO_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_term      = 1'b0;
        w_rsp_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fifo_nempty) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // A bus response on the same edge as the timeout wins.
                if (ack_i || err_i || w_timeout) begin
                    w_term      = 1'b1;
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready_i) begin
                    w_rsp_done = 1'b1;
                    if (w_fifo_nempty) begin
                        w_launch    = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wishbone request registers and timeout counter
    // ------------------------------------------------------------------
    // adr/dat/we are cleared at termination so the bus never idles with
    // stale or undefined values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_to_cnt <= '0;
        end else begin
            if (w_launch) begin
                r_we     <= w_head_we;
                r_adr    <= w_head_adr;
                r_dat    <= w_head_dat;
                r_to_cnt <= '0;
            end else if (w_term) begin
                r_we     <= 1'b0;
                r_adr    <= '0;
                r_dat    <= '0;
            end else if ((r_state == S_REQ) && TO_EN) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_we     <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_OK;
        end else begin
            if (w_term) begin
                r_rsp_we <= r_we;
                if (err_i) begin
                    r_rsp_status <= ST_ERR;
                    r_rsp_dat    <= '0;
                end else if (ack_i) begin
                    r_rsp_status <= ST_OK;
                    r_rsp_dat    <= r_we ? '0 : dat_i;
                end else begin
                    r_rsp_status <= ST_TIMEOUT;
                    r_rsp_dat    <= '0;
                end
            end else if (w_rsp_done) begin
                r_rsp_we     <= 1'b0;
                r_rsp_dat    <= '0;
                r_rsp_status <= ST_OK;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cyc_o        = (r_state == S_REQ);
    assign stb_o        = (r_state == S_REQ);
    assign we_o         = r_we;
    assign adr_o        = r_adr;
    assign dat_o        = r_dat;

    assign rsp_valid_o  = (r_state == S_RSP);
    assign rsp_we_o     = r_rsp_we;
    assign rsp_dat_o    = r_rsp_dat;
    assign rsp_status_o = r_rsp_status;

    assign cmd_count_o  = r_count;
    assign busy_o       = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 3;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic          rsp_we_o;
    logic [DW-1:0] rsp_dat_o;
    logic [1:0]    rsp_status_o;
    logic [CW-1:0] cmd_count_o;
    logic          busy_o;
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i;
    logic          ack_i;
    logic          err_i;

    always #5 clk_i = ~clk_i;

    wb_cmd_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .CMD_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_we_o    (rsp_we_o),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_status_o(rsp_status_o),
        .cmd_count_o (cmd_count_o),
        .busy_o      (busy_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .ack_i       (ack_i),
        .err_i       (err_i)
    );

    // Slave behaviour per command: mode 0 ack, 1 err, 2 ack+err, 3 silent.
    // delay = 0-based REQ cycle in which the slave answers.
    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        int            delay;
        int            mode;
        logic [DW-1:0] rdata;
    } cmd_t;

    typedef struct {
        logic          we;
        logic [DW-1:0] dat;
        logic [1:0]    status;
    } rsp_t;

    cmd_t cyc_q[$];
    rsp_t rsp_q[$];
    cmd_t cur;
    bit   cur_v   = 1'b0;
    bit   in_cyc  = 1'b0;
    int   cyc_len = 0;
    int   errors  = 0;
    int   checks  = 0;

    assign ack_i = cyc_o && cur_v && (cyc_len == cur.delay + 1) && (cur.mode == 0 || cur.mode == 2);
    assign err_i = cyc_o && cur_v && (cyc_len == cur.delay + 1) && (cur.mode == 1 || cur.mode == 2);
    assign dat_i = cur_v ? cur.rdata : '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit times_out(input cmd_t c);
        return (c.mode == 3) || (c.delay > int'(TMO));
    endfunction

    function automatic int exp_len(input cmd_t c);
        return times_out(c) ? int'(TMO) + 1 : c.delay + 1;
    endfunction

    function automatic rsp_t exp_rsp(input cmd_t c);
        rsp_t r;
        r.we = c.we;
        if (times_out(c))                    r.status = 2'b10;
        else if (c.mode == 1 || c.mode == 2) r.status = 2'b01;
        else                                 r.status = 2'b00;
        r.dat = (r.status == 2'b00 && !c.we) ? c.rdata : '0;
        return r;
    endfunction

    // Bus and response monitor: pops the scoreboard as the DUT produces activity.
    always @(negedge clk_i) begin
        if (rst_i) begin
            in_cyc  = 1'b0;
            cur_v   = 1'b0;
            cyc_len = 0;
        end else begin
            if (cyc_o) begin
                if (!in_cyc) begin
                    in_cyc  = 1'b1;
                    cyc_len = 0;
                    checks++;
                    assert (cyc_q.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_cycle: observed adr=%0h expected no bus cycle", adr_o);
                    end
                    if (cyc_q.size() != 0) begin
                        cur   = cyc_q.pop_front();
                        cur_v = 1'b1;
                    end
                end
                cyc_len++;
                check("cyc_stb", stb_o, 1'b1);
                check("cyc_no_rsp", rsp_valid_o, 1'b0);
                if (cur_v) begin
                    check("cyc_adr", adr_o, cur.adr);
                    check("cyc_we", we_o, cur.we);
                    check("cyc_dat", dat_o, cur.dat);
                end
            end else if (in_cyc) begin
                in_cyc = 1'b0;
                if (cur_v) begin
                    check("cyc_len", cyc_len, exp_len(cur));
                end
                check("idle_bus", {stb_o, we_o, adr_o, dat_o}, '0);
                cur_v = 1'b0;
            end

            if (rsp_valid_o && rsp_ready_i) begin
                checks++;
                assert (rsp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_rsp: observed status=%0h expected no response", rsp_status_o);
                end
                if (rsp_q.size() != 0) begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("rsp_we", rsp_we_o, r.we);
                    check("rsp_dat", rsp_dat_o, r.dat);
                    check("rsp_status", rsp_status_o, r.status);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one command and wait for acceptance; leaves cmd_valid_i high so
    // consecutive calls push back-to-back.
    task automatic send(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input int delay, input int mode, input logic [DW-1:0] rdata);
        cmd_t c;
        int   n;
        c.we = we; c.adr = adr; c.dat = dat; c.delay = delay; c.mode = mode; c.rdata = rdata;
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        n = 0;
        while (!cmd_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready_o) begin
            check("push_ready", cmd_ready_o, 1'b1);
            cmd_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        cyc_q.push_back(c);
        rsp_q.push_back(exp_rsp(c));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy_o || rsp_valid_o || cyc_q.size() != 0 || rsp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, {busy_o, rsp_valid_o, cyc_q.size() != 0, rsp_q.size() != 0}, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        rsp_ready_i = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_outputs", {cyc_o, stb_o, we_o, rsp_valid_o, rsp_we_o, busy_o}, '0);
        check("rst_buses", {adr_o, dat_o, rsp_dat_o, rsp_status_o}, '0);
        check("rst_count", cmd_count_o, '0);
        check("rst_ready", cmd_ready_o, 1'b0);
        #2 rst_i = 1'b0;
        tick();
        check("ready_after_rst", cmd_ready_o, 1'b1);

        // Single write, ack in 2nd REQ cycle; launch one edge after push
        send(1'b1, 32'h0000_0004, 16'h00A5, 1, 0, 16'h5555);
        cmd_valid_i = 1'b0;
        check("launch_pre", cyc_o, 1'b0);
        check("count_after_push", cmd_count_o, 1);
        tick();
        check("launch", cyc_o, 1'b1);
        check("count_after_pop", cmd_count_o, 0);
        wait_idle("write");

        // Single read, ack in 1st REQ cycle
        send(1'b0, 32'h0000_0008, 16'h0000, 0, 0, 16'h1234);
        cmd_valid_i = 1'b0;
        wait_idle("read");

        // Minimum latency: REQ, RSP, next REQ
        send(1'b0, 32'h0000_000C, 16'h0000, 0, 0, 16'h0C0C);
        send(1'b1, 32'h0000_0010, 16'hC0DE, 0, 0, 16'h9999);
        cmd_valid_i = 1'b0;
        check("lat_req0", cyc_o, 1'b1);
        tick();
        check("lat_rsp", {cyc_o, rsp_valid_o}, 2'b01);
        tick();
        check("lat_req1", cyc_o, 1'b1);
        wait_idle("latency");

        // Queue full with response held off
        rsp_ready_i = 1'b0;
        send(1'b0, 32'h0000_0100, 16'h0000, 0, 0, 16'h1111);
        send(1'b1, 32'h0000_0104, 16'hA001, 1, 0, 16'h2222);
        send(1'b0, 32'h0000_0108, 16'h0000, 2, 0, 16'h3333);
        send(1'b1, 32'h0000_010C, 16'hA003, 0, 0, 16'h4444);
        send(1'b0, 32'h0000_0110, 16'h0000, 1, 0, 16'h5555);
        check("full_count", cmd_count_o, 4);
        check("full_ready", cmd_ready_o, 1'b0);
        check("full_busy", busy_o, 1'b1);
        cmd_we_i  = 1'b1;
        cmd_adr_i = 32'h0000_0DEA;
        cmd_dat_i = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_hold_count", cmd_count_o, 4);
            check("full_hold_ready", cmd_ready_o, 1'b0);
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        wait_idle("full");

        // Error priority: ack+err, then err alone
        send(1'b0, 32'h0000_0200, 16'h0000, 0, 2, 16'hBEEF);
        send(1'b1, 32'h0000_0204, 16'h0F0F, 1, 1, 16'h7777);
        cmd_valid_i = 1'b0;
        wait_idle("error");

        // Timeout, then normal command, then ack on the timeout edge
        send(1'b0, 32'h0000_0300, 16'h0000, 0, 3, 16'hAAAA);
        send(1'b0, 32'h0000_0304, 16'h0000, 2, 0, 16'h4321);
        send(1'b1, 32'h0000_0308, 16'h1111, 3, 0, 16'h6666);
        cmd_valid_i = 1'b0;
        wait_idle("timeout");

        // Response backpressure
        rsp_ready_i = 1'b0;
        send(1'b0, 32'h0000_0400, 16'h0000, 0, 0, 16'h0BAD);
        send(1'b1, 32'h0000_0404, 16'h2222, 0, 0, 16'h8888);
        cmd_valid_i = 1'b0;
        begin
            int   n;
            rsp_t r;
            n = 0;
            while (!rsp_valid_o && n < 50) begin
                tick();
                n++;
            end
            check("bp_valid", rsp_valid_o, 1'b1);
            r = rsp_q[0];
            for (int i = 0; i < 5; i++) begin
                check("bp_hold_valid", rsp_valid_o, 1'b1);
                check("bp_hold_rsp", {rsp_we_o, rsp_dat_o, rsp_status_o}, {r.we, r.dat, r.status});
                check("bp_no_cyc", cyc_o, 1'b0);
                check("bp_count", cmd_count_o, 1);
                tick();
            end
        end
        rsp_ready_i = 1'b1;
        wait_idle("backpressure");

        // Reset in the middle of a REQ with another command queued
        send(1'b0, 32'h0000_0500, 16'h0000, 0, 3, 16'h0000);
        send(1'b1, 32'h0000_0504, 16'h3333, 0, 0, 16'h0000);
        cmd_valid_i = 1'b0;
        check("pre_rst_cyc", cyc_o, 1'b1);
        tick();
        #2 rst_i = 1'b1;
        #1;
        check("rst_mid_cyc", {cyc_o, stb_o}, 2'b00);
        check("rst_mid_count", cmd_count_o, 0);
        check("rst_mid_rsp", rsp_valid_o, 1'b0);
        check("rst_mid_ready", cmd_ready_o, 1'b0);
        check("rst_mid_bus", {we_o, adr_o, dat_o}, '0);
        cyc_q.delete();
        rsp_q.delete();
        tick();
        tick();
        #2 rst_i = 1'b0;
        repeat (20) tick();
        check("post_rst_quiet", {busy_o, cyc_o, rsp_valid_o}, '0);
        check("post_rst_count", cmd_count_o, 0);
        check("post_rst_ready", cmd_ready_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
